button_speed_select: RTL and testbench

//   Upstream of the LED cycling stage. Conditions the five raw board buttons and produces a held one-hot speed select.
//   - Per button: 2-flop synchronise, then debounce.
//   - A press is latched, so the speed persists after the button is released.
//   - Output drives the LED stage's buttons[4:0] input; that input otherwise falls back to slowest whenever no button is held.

---
 rtl/speed_pkg.sv | 7 +
 rtl/button_debouncer.sv | 47 ++++
 rtl/button_speed_select.sv | 57 +++++
 tb/tb_button_speed_select.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Speed-select types shared by the button front end and the LED cycling stage.
package speed_pkg;
  localparam int NUM_SPEED_BTN = 5;
  typedef logic [NUM_SPEED_BTN-1:0] speed_sel_t;
  localparam speed_sel_t SPEED_SLOWEST = 5'b00001;
  localparam speed_sel_t SPEED_FASTEST = 5'b10000;
endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser, consecutive-mismatch debounce counter,
// accepted level and a press (rising-accept) strobe.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int unsigned    CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mismatch, accept;

  assign mismatch = (sync2_q != level_q);
  assign accept   = mismatch && (cnt_q == CNT_LAST);

  // Counter only advances while mismatched, and is cleared on accept, so it never wraps.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (accept)        level_d = sync2_q;
    else if (mismatch) cnt_d   = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_d & ~level_q;
endmodule

// File: rtl/button_speed_select.sv
// Debounces the speed buttons and latches the lowest-index new press as a
// held one-hot speed select, pulsing speed_changed when it moves.
module button_speed_select
  import speed_pkg::*;
#(
  parameter int unsigned NUM_BTN         = NUM_SPEED_BTN,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter speed_sel_t  DEFAULT_SEL     = SPEED_SLOWEST
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] buttons,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               speed_changed
);
  logic [NUM_BTN-1:0] rise, cand;
  logic [NUM_BTN-1:0] sel_q, sel_d;
  logic               chg_q, chg_d;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw_i(btn_raw[i]),
      .level_o  (btn_level[i]),
      .rise_o   (rise[i])
    );
  end

  // Isolate the lowest set bit: simultaneous presses resolve to the slower speed.
  assign cand = rise & (~rise + NUM_BTN'(1));

  always_comb begin
    sel_d = sel_q;
    chg_d = 1'b0;
    if ((|rise) && (cand != sel_q)) begin
      sel_d = cand;
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= NUM_BTN'(DEFAULT_SEL);
      chg_q <= 1'b0;
    end else begin
      sel_q <= sel_d;
      chg_q <= chg_d;
    end
  end

  assign buttons       = sel_q;
  assign speed_changed = chg_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot(sel_q));
endmodule

// File: tb/tb_button_speed_select.sv
// Directed bench for button_speed_select with a sliding-window debounce model.
module tb_button_speed_select;
  import speed_pkg::*;
  localparam int NB = 5;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] buttons, btn_level;
  logic          speed_changed;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  button_speed_select #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(D), .DEFAULT_SEL(SPEED_SLOWEST)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .buttons      (buttons),
    .btn_level    (btn_level),
    .speed_changed(speed_changed)
  );

  always #5 clk = ~clk;

  // Model: a level is accepted once the last D synchronised samples all
  // disagree with it; a newly accepted 1 is a press.
  logic [NB-1:0]         m_s1, m_s2, m_lvl, m_sel;
  logic [D-1:0][NB-1:0]  m_win;
  logic                  m_chg;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_win <= '0;
      m_sel <= SPEED_SLOWEST; m_chg <= 1'b0;
    end else begin : step
      logic [D-1:0][NB-1:0] w;
      logic [NB-1:0]        lvl, rise, pick;
      logic                 all_diff;
      w    = {m_win[D-2:0], m_s2};
      lvl  = m_lvl;
      rise = '0;
      pick = '0;
      for (int i = 0; i < NB; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (w[j][i] == m_lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          lvl[i] = ~m_lvl[i];
          if (lvl[i]) rise[i] = 1'b1;
        end
      end
      for (int i = NB - 1; i >= 0; i--) if (rise[i]) pick = NB'(1) << i;
      m_win <= w;
      m_s2  <= m_s1;
      m_s1  <= btn_raw;
      m_lvl <= lvl;
      if (rise != '0 && pick != m_sel) begin
        m_sel <= pick;
        m_chg <= 1'b1;
      end else begin
        m_chg <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      tests++;
      if (buttons !== m_sel || btn_level !== m_lvl || speed_changed !== m_chg) begin
        fails++;
        $display("FAIL model t=%0t buttons=%b/%b level=%b/%b chg=%b/%b (got/expected)",
                 $time, buttons, m_sel, btn_level, m_lvl, speed_changed, m_chg);
      end
      if (speed_changed === 1'b1) pulses++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p0;

  initial begin
    rst_n = 1'b0; btn_raw = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    check("reset_buttons", 32'(buttons), 32'b00001);
    check("reset_level", 32'(btn_level), 0);

    // 1. async reset mid-run
    btn_raw = 5'b00010; tick(12); btn_raw = '0;
    check("pre_reset_sel", 32'(buttons), 32'b00010);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_buttons", 32'(buttons), 32'b00001);
    check("async_rst_level", 32'(btn_level), 0);
    check("async_rst_chg", 32'(speed_changed), 0);
    tick(2); rst_n = 1'b1; tick(2);

    // 2. clean press, 10-cycle latency
    btn_raw = 5'b01000;
    tick(9);
    check("press_lvl_early", 32'(btn_level[3]), 0);
    tick(1);
    check("press_lvl_edge", 32'(btn_level[3]), 1);
    check("press_sel", 32'(buttons), 32'b01000);
    check("press_pulse", 32'(speed_changed), 1);
    tick(1);
    check("press_pulse_end", 32'(speed_changed), 0);
    tick(9); btn_raw = '0; tick(12);
    check("release_hold", 32'(buttons), 32'b01000);
    check("release_lvl", 32'(btn_level), 0);

    // 3. bounce on bit4
    p0 = pulses;
    for (int c = 0; c < 30; c++) begin
      btn_raw = ((c / 3) % 2 == 0) ? 5'b10000 : 5'b00000;
      tick(1);
    end
    btn_raw = '0; tick(12);
    check("bounce_lvl", 32'(btn_level), 0);
    check("bounce_sel", 32'(buttons), 32'b01000);
    check("bounce_pulses", 32'(pulses - p0), 0);

    // 4. simultaneous press
    p0 = pulses;
    btn_raw = 5'b10010; tick(12);
    check("simul_sel", 32'(buttons), 32'b00010);
    check("simul_pulses", 32'(pulses - p0), 1);
    btn_raw = '0; tick(12);

    // 5. re-press current selection
    btn_raw = 5'b00100; tick(12); btn_raw = '0; tick(12);
    check("sel_bit2", 32'(buttons), 32'b00100);
    p0 = pulses;
    btn_raw = 5'b00100; tick(12);
    check("repress_sel", 32'(buttons), 32'b00100);
    check("repress_pulses", 32'(pulses - p0), 0);
    btn_raw = '0; tick(12);

    // 6. reset mid-debounce with button held through release
    btn_raw = 5'b10000; tick(5);
    check("mid_deb_sel", 32'(buttons), 32'b00100);
    rst_n = 1'b0;
    #1 check("mid_deb_rst", 32'(buttons), 32'b00001);
    tick(1); rst_n = 1'b1;
    tick(9);
    check("post_rst_early", 32'(buttons), 32'b00001);
    tick(1);
    check("post_rst_press", 32'(buttons), 32'(SPEED_FASTEST));
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
